// File: rtl/video_fetch.sv
// video_fetch
//   Fetches character codes from video RAM and their glyph rows from the
//   character ROM over a pipelined Wishbone B4 controller port, then queues
//   the assembled pixel bytes (plus the per-character reverse-video bit) in
//   a small FIFO for the display shifter.
//
//   Optional feature macro: VIDEO_FETCH_TIMEOUT_EN
//     defined   -> an ack that never arrives is replaced by byte 8'h00 after
//                  TIMEOUT_CYCLES cycles and timeout_o is set (sticky)
//     undefined -> the controller waits for ack indefinitely, timeout_o = 0
//
// Ports
//   wb_clock_i      single clock
//   reset_i         synchronous, active-high reset
//   start_i         one-cycle pulse: fetch one FIFO entry using the context below
//   ma_i, ra_i      memory address / row address of the character cell
//   col_80_mode_i   1: 80-column (CHARS_PER_CCLK chars per entry), 0: 40-column
//   graphic_i, chr_option_i  ROM bank selects
//   wb_*            Wishbone B4 pipelined controller (read only)
//   pixels_o        head entry ROM bytes, char 0 in the MSBs
//   reverse_o       head entry bit 7 of each RAM byte, char 0 in the MSB
//   valid_o         FIFO not empty
//   pop_i           consumer removes the head entry
//   overrun_o       sticky: a start_i pulse was dropped
//   timeout_o       sticky: an ack timed out
module video_fetch #(
   parameter int CHARS_PER_CCLK = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int WB_ADDR_WIDTH  = 13,
   parameter int DATA_WIDTH     = 8
) (
   input  logic                        wb_clock_i,
   input  logic                        reset_i,
   input  logic                        start_i,
   input  logic [9:0]                  ma_i,
   input  logic [2:0]                  ra_i,
   input  logic                        col_80_mode_i,
   input  logic                        graphic_i,
   input  logic                        chr_option_i,
   output logic [WB_ADDR_WIDTH-1:0]    wb_addr_o,
   input  logic [DATA_WIDTH-1:0]       wb_data_i,
   output logic                        wb_we_o,
   output logic                        wb_cycle_o,
   output logic                        wb_strobe_o,
   input  logic                        wb_stall_i,
   input  logic                        wb_ack_i,
   output logic [8*CHARS_PER_CCLK-1:0] pixels_o,
   output logic [CHARS_PER_CCLK-1:0]   reverse_o,
   output logic                        valid_o,
   input  logic                        pop_i,
   output logic                        overrun_o,
   output logic                        timeout_o
);

   localparam int PW    = 8 * CHARS_PER_CCLK;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RAM_REQ,
      S_RAM_ACK,
      S_ROM_REQ,
      S_ROM_ACK,
      S_PUSH
   } state_t;

   state_t state_q, state_d;

   // Latched fetch context
   logic [9:0]  ma_q;
   logic [2:0]  ra_q;
   logic        col80_q;
   logic        graphic_q;
   logic        chr_q;
   logic        k_q;
   logic [6:0]  ram_char_q;
   logic [PW-1:0]             pix_acc_q;
   logic [CHARS_PER_CCLK-1:0] rev_acc_q;

   // FIFO storage
   logic [PW-1:0]             fifo_pix [FIFO_DEPTH];
   logic [CHARS_PER_CCLK-1:0] fifo_rev [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]          count_q;

   logic overrun_q, timeout_q;

   logic fifo_full, do_pop, do_push, accept, in_ack, ack_event, last_char;
   logic timeout_hit;
   logic [7:0]                ack_byte;
   logic [PW-1:0]             pix_lane;
   logic [CHARS_PER_CCLK-1:0] rev_lane;
   logic [10:0]               vram_index;
   logic [11:0]               vrom_index;

   // Video RAM sits at the bottom of the bus map, the character ROM is
   // selected by bit 12.
   function automatic logic [WB_ADDR_WIDTH-1:0] wb_vram_addr(input logic [10:0] idx);
      return WB_ADDR_WIDTH'(idx);
   endfunction

   function automatic logic [WB_ADDR_WIDTH-1:0] wb_vrom_addr(input logic [11:0] idx);
      return WB_ADDR_WIDTH'({1'b1, idx});
   endfunction

`ifdef VIDEO_FETCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q;

   assign timeout_hit = in_ack && (timer_q == TW'(TIMEOUT_CYCLES));

   // Counts cycles spent waiting for ack; cleared whenever the wait ends.
   always_ff @(posedge wb_clock_i) begin
      if (reset_i || !in_ack || ack_event) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
`endif

   assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
   assign do_pop    = pop_i && (count_q != '0);
   assign do_push   = (state_q == S_PUSH);
   // A slot being popped this cycle counts as free for the incoming request.
   assign accept    = (state_q == S_IDLE) && start_i && (!fifo_full || do_pop);
   assign in_ack    = (state_q == S_RAM_ACK) || (state_q == S_ROM_ACK);
   assign ack_event = in_ack && (wb_ack_i || timeout_hit);
   assign ack_byte  = wb_ack_i ? wb_data_i[7:0] : 8'h00;
   // 40-column entries carry a single character in lane 0.
   assign last_char = col80_q ? (k_q == 1'(CHARS_PER_CCLK - 1)) : 1'b1;

   assign vram_index = col80_q ? {ma_q, k_q} : {1'b0, ma_q};
   assign vrom_index = {chr_q, graphic_q, ram_char_q, ra_q};

   // Place the incoming byte/bit into lane k, counting lanes from the MSB.
   assign pix_lane = (PW'(ack_byte) << (PW - 8)) >> {k_q, 3'b000};
   assign rev_lane = (CHARS_PER_CCLK'(ack_byte[7]) << (CHARS_PER_CCLK - 1)) >> k_q;

   // Next-state and bus outputs. Address is only driven in request states;
   // it is derived from registered context so it stays put while stalled.
   always_comb begin
      state_d     = state_q;
      wb_cycle_o  = 1'b0;
      wb_strobe_o = 1'b0;
      wb_addr_o   = '0;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_RAM_REQ;
         end
         S_RAM_REQ: begin
            wb_cycle_o  = 1'b1;
            wb_strobe_o = 1'b1;
            wb_addr_o   = wb_vram_addr(vram_index);
            if (!wb_stall_i) state_d = S_RAM_ACK;
         end
         S_RAM_ACK: begin
            wb_cycle_o = !timeout_hit;
            if (ack_event) state_d = S_ROM_REQ;
         end
         S_ROM_REQ: begin
            wb_cycle_o  = 1'b1;
            wb_strobe_o = 1'b1;
            wb_addr_o   = wb_vrom_addr(vrom_index);
            if (!wb_stall_i) state_d = S_ROM_ACK;
         end
         S_ROM_ACK: begin
            wb_cycle_o = !timeout_hit;
            if (ack_event) state_d = last_char ? S_PUSH : S_RAM_REQ;
         end
         S_PUSH: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, context capture, entry assembly, FIFO bookkeeping and sticky flags.
   always_ff @(posedge wb_clock_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         ma_q       <= '0;
         ra_q       <= '0;
         col80_q    <= 1'b0;
         graphic_q  <= 1'b0;
         chr_q      <= 1'b0;
         k_q        <= 1'b0;
         ram_char_q <= '0;
         pix_acc_q  <= '0;
         rev_acc_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q <= state_d;

         if (start_i && !accept) overrun_q <= 1'b1;
         if (timeout_hit && !wb_ack_i) timeout_q <= 1'b1;

         if (accept) begin
            ma_q      <= ma_i;
            ra_q      <= ra_i;
            col80_q   <= col_80_mode_i;
            graphic_q <= graphic_i;
            chr_q     <= chr_option_i;
            k_q       <= 1'b0;
            pix_acc_q <= '0;
            rev_acc_q <= '0;
         end

         if ((state_q == S_RAM_ACK) && ack_event) begin
            ram_char_q <= ack_byte[6:0];
            rev_acc_q  <= rev_acc_q | rev_lane;
         end

         if ((state_q == S_ROM_ACK) && ack_event) begin
            pix_acc_q <= pix_acc_q | pix_lane;
            if (!last_char) k_q <= k_q + 1'b1;
         end

         if (do_push) begin
            fifo_pix[wr_ptr_q] <= pix_acc_q;
            fifo_rev[wr_ptr_q] <= rev_acc_q;
            wr_ptr_q           <= wr_ptr_q + 1'b1;
         end

         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;

         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign wb_we_o   = 1'b0;
   assign valid_o   = (count_q != '0);
   assign pixels_o  = valid_o ? fifo_pix[rd_ptr_q] : '0;
   assign reverse_o = valid_o ? fifo_rev[rd_ptr_q] : '0;
   assign overrun_o = overrun_q;
   assign timeout_o = timeout_q;

endmodule

// File: doc/video_fetch.md
VIDEO_FETCH -- requirements
Module: video_fetch

Interface
REQ-001 SHALL have parameter CHARS_PER_CCLK, default 2; characters fetched per start pulse; legal values 1 or 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; number of output entries; power of two, 2..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64; ack wait limit, used only under REQ-031.
REQ-004 wb_clock_i  in  1  single clock for all logic.
REQ-005 reset_i  in  1  reset, synchronous, active-high.
REQ-006 start_i  in  1  one-cycle pulse: new MA/RA valid, begin fetching one entry.
REQ-007 ma_i  in  10; ra_i  in  3; col_80_mode_i  in  1; graphic_i  in  1; chr_option_i  in  1  fetch context, sampled on accepted start_i.
REQ-008 wb_addr_o  out  WB_ADDR_WIDTH; wb_data_i  in  DATA_WIDTH; wb_we_o, wb_cycle_o, wb_strobe_o  out  1; wb_stall_i, wb_ack_i  in  1  Wishbone B4 pipelined controller.
REQ-009 pixels_o  out  8*CHARS_PER_CCLK  ROM bytes, char 0 in MSBs; reverse_o  out  CHARS_PER_CCLK  bit 7 of each RAM byte, char 0 in MSB.
REQ-010 valid_o  out  1  FIFO non-empty; pop_i  in  1  consumer removes head entry.
REQ-011 overrun_o  out  1  sticky: start_i dropped; timeout_o  out  1  sticky: ack timeout.

Function
REQ-012 States: IDLE, RAM_REQ, RAM_ACK, ROM_REQ, ROM_ACK, PUSH.
REQ-013 IDLE + start_i + FIFO not full -> latch context, char index k=0, go RAM_REQ.
REQ-014 start_i outside IDLE, or with FIFO full, SHALL be dropped and set overrun_o; no other effect.
REQ-015 RAM address k: 80-col wb_vram_addr({ma,k}); 40-col wb_vram_addr({1'b0,ma}) with k forced 0 and CHARS_PER_CCLK treated as 1 for that entry (unused lanes zero).
REQ-016 ROM address k: wb_vrom_addr({chr_option, graphic, ram_byte_k[6:0], ra}).
REQ-017 *_REQ: assert cycle and strobe with address; advance to *_ACK in the first cycle wb_stall_i is low; hold address while stalled.
REQ-018 *_ACK: strobe low, cycle high; on wb_ack_i capture wb_data_i; RAM_ACK -> ROM_REQ; ROM_ACK -> RAM_REQ with k+1, or PUSH after last char.
REQ-019 PUSH: write entry, deassert cycle, return to IDLE; exactly one cycle.
REQ-020 wb_we_o SHALL be constantly 0.
REQ-021 Ack outside an *_ACK state SHALL be ignored.
REQ-022 Latency: start_i to valid_o with zero-wait peripheral (ack one cycle after accept) = 4*CHARS_PER_CCLK+2 cycles.
REQ-023 FIFO: push and pop same cycle when full or non-empty SHALL both succeed; pop_i when empty ignored; pointers wrap modulo FIFO_DEPTH.
REQ-024 pixels_o/reverse_o SHALL present head entry combinationally from FIFO storage; undefined-free (zero) when empty.
REQ-025 Full check in IDLE SHALL count the entry being popped that cycle as free.

Reset
REQ-026 reset_i SHALL, next edge: state IDLE, cycle/strobe 0, FIFO empty, valid_o 0, pixels_o/reverse_o 0, overrun_o 0, timeout_o 0, wb_addr_o 0.
REQ-027 Reset mid-transaction SHALL abandon the cycle; a later ack SHALL be ignored per REQ-021.
REQ-028 start_i during reset SHALL be ignored and not set overrun_o.
REQ-029 Sticky flags clear only by reset.

Configuration
REQ-030 Macro VIDEO_FETCH_TIMEOUT_EN selects ack timeout.
REQ-031 Defined: counter counts cycles in *_ACK; reaching TIMEOUT_CYCLES substitutes byte 8'h00, deasserts cycle for one cycle, sets timeout_o, continues as if acked.
REQ-032 Undefined: no counter, *_ACK waits indefinitely, timeout_o tied 0.

Verification
REQ-033 80-col, ma=0x155, ra=3, zero-wait, RAM=0x81/0x02 -> addresses vram 0x2AA,0x2AB; ROM {0,0,0x01,3},{0,0,0x02,3}; reverse_o=2'b10, valid_o at cycle 10.
REQ-034 40-col, ma=0x3FF, CHARS=2 -> single vram 0x3FF fetch, upper lane only, lower lanes zero.
REQ-035 wb_stall_i high 5 cycles on first RAM_REQ -> address held stable, strobe held, latency +5.
REQ-036 FIFO_DEPTH=4, no pops, 5 starts spaced 12 cycles -> 4 entries, 5th dropped, overrun_o=1; then pop+start same cycle -> accepted.
REQ-037 Reset asserted in ROM_ACK, ack arrives next cycle -> cycle 0, FIFO empty, no entry pushed.
REQ-038 With VIDEO_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, never ack -> timeout_o=1 after 8 cycles, entry pushed with pixels_o=0.
